ifetch_buffered: RTL and testbench
==================================

# ifetch_buffered

Parametrised, buffered instruction-fetch stage. It owns the PC, issues sequential fetches to a fixed-latency synchronous instruction memory, queues returned instructions in a prefetch FIFO, and hands them to decode over a valid/ready handshake. It sits between the PC/branch logic and decode, replacing the unbuffered single-instruction fetch path, and adds stall tolerance, redirect flushing and configurable depth and width.

## Interface
- WORD, 32, PC/address width
- INSTR_LEN, 32, instruction width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, sequential PC increment
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- redirect  in  1  branch/jump taken; replaces pc_src
- redirect_pc  in  WORD  new fetch target; replaces branch_target
- imem_req  out  1  fetch request this cycle
- imem_addr  out  WORD  fetch address; valid while imem_req=1
- imem_rdata  in  INSTR_LEN  instruction; valid exactly 1 cycle after imem_req
- out_valid  out  1  FIFO head holds an instruction
- out_ready  in  1  decode accepts the head
- out_instr  out  INSTR_LEN  head instruction
- out_pc  out  WORD  address of out_instr
- out_pc_next  out  WORD  out_pc + PC_STEP, truncated to WORD bits

## Operation
- Reset, asynchronous while reset=0: fetch_pc=RESET_PC; FIFO empty; in-flight flag clear; imem_req=0; out_valid=0; out_instr, out_pc and out_pc_next all 0.
- Issue rule: imem_req=1 when count + inflight < DEPTH and redirect=0. imem_addr=fetch_pc. On issue, fetch_pc += PC_STEP, which wraps modulo 2^WORD, and inflight is set for one cycle.
- Response: in the cycle after an issue, imem_rdata is pushed together with its address, unless the request was squashed.
- Pop: out_valid & out_ready removes the head.
- Push and pop in the same cycle leave count unchanged. This is legal when full or when empty, because the issue rule guarantees room.
- Redirect: in the redirect cycle, fetch_pc←redirect_pc, the FIFO is flushed, the in-flight response is squashed and imem_req=0. A handshake in the same cycle still completes; the flush follows it.
- Redirect during reset is ignored.
- Back-to-back redirects: the last one wins.
- A redirect while empty with nothing in flight is legal.
- out_pc_next is derived combinationally from the stored out_pc.
- count width is $clog2(DEPTH+1). Pointer width is $clog2(DEPTH); pointers wrap naturally.

## Timing
- Redirect in cycle N: request to redirect_pc in N+1, data captured at the end of N+2, out_valid=1 in N+3. Redirect-to-valid latency is 3 cycles.
- After reset deasserts, the first request is in cycle 0 and out_valid rises in cycle 2.
- Steady state with out_ready=1: one instruction per cycle, no bubbles.
- Stall (out_ready=0) with DEPTH entries buffered: imem_req=0 until space frees. At most one request is ever outstanding beyond capacity, and that request is covered by the count + inflight rule.
- out_valid, out_instr and out_pc are registered outputs. out_pc_next is combinational from out_pc.

## Configuration
- IFETCH_PERF_EN defined: adds outputs perf_fetched[31:0], counting pops, and perf_stall[31:0], counting cycles with out_valid=1 and out_ready=0. Both reset to 0, wrap at 2^32 and are unaffected by redirect.
- IFETCH_PERF_EN undefined: neither port nor the counter logic exists.

## Structure
- Shared package/header holds the WORD and INSTR_LEN defaults, the RESET_PC default and PC_STEP.
- One sub-module: fetch_fifo, a parametrised synchronous FIFO of {WORD+INSTR_LEN}-bit entries with push, pop, flush, count, full and empty.
- PC, issue and squash logic stay in ifetch_buffered.

## Test plan
- Reset then out_ready=1, memory returns 0x1000_0000+addr: out_pc sequence 0,4,8,… one per cycle from cycle 2; out_pc_next = out_pc+4.
- Hold out_ready=0 for 10 cycles, DEPTH=4: exactly 4 entries buffered, imem_req=0 afterwards. Releasing gives 4 in-order pops, then the stream continues with no gap or duplicate.
- Redirect to 0x200 while 3 entries are buffered and one is in flight: FIFO flushed, stale response dropped, next out_pc=0x200 exactly 3 cycles later.
- Redirect coinciding with a handshake of out_pc=0x8: 0x8 consumed once, next delivered out_pc is the target.
- fetch_pc=0xFFFF_FFFC with WORD=32: next request address 0x0, out_pc_next=0x0.
- Assert reset mid-stream with FIFO full: outputs go to 0 asynchronously; after release, fetch restarts at RESET_PC. With IFETCH_PERF_EN, counters read 0 after reset and match the pop and stall totals.

Source files
------------

// File: rtl/ifetch_buffered_pkg.sv
// Shared defaults for the buffered instruction-fetch stage.
package ifetch_buffered_pkg;

  localparam int unsigned WORD_DEFAULT      = 32;
  localparam int unsigned INSTR_LEN_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT     = 4;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT   = 4;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifetch_buffered_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} entries with push, pop, flush and occupancy status.
module fetch_fifo
  import ifetch_buffered_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned CW   = count_width(DEPTH),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop frees the head in the same cycle, so push-while-full is fine alongside it.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage is reset so the head reads as zero coming out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_d;
      end
    end
  end

  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_buffered.sv
// Buffered sequential instruction fetch with redirect flush; optional perf counters
// are built when IFETCH_PERF_EN is defined.
module ifetch_buffered
  import ifetch_buffered_pkg::*;
#(
  parameter int unsigned         WORD      = WORD_DEFAULT,
  parameter int unsigned         INSTR_LEN = INSTR_LEN_DEFAULT,
  parameter int unsigned         DEPTH     = DEPTH_DEFAULT,
  parameter logic [WORD-1:0]     RESET_PC  = WORD'(RESET_PC_DEFAULT),
  parameter int unsigned         PC_STEP   = PC_STEP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect,
  input  logic [WORD-1:0]      redirect_pc,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_LEN-1:0] out_instr,
  output logic [WORD-1:0]      out_pc,
  output logic [WORD-1:0]      out_pc_next
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  localparam int unsigned CW = count_width(DEPTH);
  localparam int unsigned EW = WORD + INSTR_LEN;
  localparam logic [CW:0] OCC_LIMIT = (CW + 1)'(DEPTH);
  localparam logic [WORD-1:0] STEP = WORD'(PC_STEP);

  logic [WORD-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD-1:0] inflight_pc_q;
  logic            inflight_q;
  logic            issue, push, pop;
  logic [CW-1:0]   count;
  logic            full, empty;
  logic [CW:0]     occupancy;
  logic [EW-1:0]   head;

  // Reserve a slot for the outstanding response so it can never overflow the FIFO.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue     = reset & ~redirect & ~full & (occupancy < OCC_LIMIT);

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  // The response arriving in a redirect cycle belongs to the old path.
  assign push = inflight_q & ~redirect;
  assign pop  = out_valid & out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({inflight_pc_q, imem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = ~empty;
  assign out_pc    = head[EW-1:INSTR_LEN];
  assign out_instr = head[INSTR_LEN-1:0];

  // Gated by empty so the reset and idle value is zero rather than PC_STEP.
  assign out_pc_next = empty ? '0 : out_pc + STEP;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch_buffered.sv
// Scoreboard bench for ifetch_buffered: expected PCs are queued on reset/redirect and
// popped on every decode handshake.
module tb_ifetch_buffered;

  localparam int unsigned WORD      = 32;
  localparam int unsigned INSTR_LEN = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PC_STEP   = 4;
  localparam logic [31:0] IBASE     = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_next;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned hs_cnt = 0;
  int unsigned req_cnt = 0;
  int unsigned tb_pops = 0;
  int unsigned tb_stalls = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ifetch_buffered #(
    .WORD      (WORD),
    .INSTR_LEN (INSTR_LEN),
    .DEPTH     (DEPTH),
    .RESET_PC  (32'h0),
    .PC_STEP   (PC_STEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_pc_next (out_pc_next)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  // One-cycle synchronous memory: data is a function of the address.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= IBASE + imem_addr;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_fill(input logic [31:0] start);
    logic [31:0] pc;
    pc = start;
    exp_q.delete();
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e, e_instr, e_next;
    if (!reset) begin
      tb_pops   = 0;
      tb_stalls = 0;
    end else begin
      if (imem_req) req_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        tb_pops++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e       = exp_q.pop_front();
          e_instr = IBASE + e;
          e_next  = e + 32'd4;
          check("out_pc", out_pc, e);
          check("out_instr", out_instr, e_instr);
          check("out_pc_next", out_pc_next, e_next);
        end
      end
      if (out_valid && !out_ready) tb_stalls++;
      // Handshake above completes first; the redirect then replaces the expected stream.
      if (redirect) sb_fill(redirect_pc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned n;
    int unsigned hs0, req0;

    // Reset state
    #12;
    check("rst_imem_req", imem_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_pc_next", out_pc_next, 0);
`ifdef IFETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 0);
    check("rst_perf_stall", perf_stall, 0);
`endif

    // Release: request in cycle 0, out_valid in cycle 2
    @(posedge clk); #1;
    reset = 1'b1;
    sb_fill(32'h0);
    out_ready = 1'b1;
    #1;
    check("c0_req", imem_req, 1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_valid", out_valid, 0);
    tick();
    check("c1_valid", out_valid, 0);
    tick();
    check("c2_valid", out_valid, 1);
    check("c2_pc", out_pc, 32'h0);

    // Steady stream, one per cycle
    hs0 = hs_cnt;
    repeat (16) tick();
    check("no_bubble", hs_cnt - hs0, 16);

    // Stall: only two more requests fit (1 buffered + 1 in flight at entry)
    out_ready = 1'b0;
    req0 = req_cnt;
    repeat (10) tick();
    #1;
    check("stall_req", imem_req, 0);
    check("stall_valid", out_valid, 1);
    check("stall_reqs", req_cnt - req0, 2);
    out_ready = 1'b1;
    hs0 = hs_cnt;
    repeat (8) tick();
    check("release_no_gap", hs_cnt - hs0, 8);

    // Redirect with buffered entries and a response in flight
    out_ready = 1'b0;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    check("redir_req", imem_req, 0);
    check("redir_buffered", out_valid, 1);
    tick();
    redirect = 1'b0;
    #1;
    check("redir_n1_req", imem_req, 1);
    check("redir_n1_addr", imem_addr, 32'h200);
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("redir_latency", n, 3);
    check("redir_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    repeat (4) tick();

    // Back-to-back redirects, the last one wins
    redirect = 1'b1;
    redirect_pc = 32'h400;
    tick();
    redirect_pc = 32'h500;
    tick();
    redirect = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("b2b_valid", out_valid, 1);
    check("b2b_pc", out_pc, 32'h500);
    repeat (3) tick();

    // Redirect coinciding with handshake of out_pc=0x8
    redirect = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    n = 0;
    while (!(out_valid && out_pc == 32'h8) && n < 20) begin
      tick();
      n++;
    end
    check("hs8_reached", out_pc, 32'h8);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("hs8_next_pc", out_pc, 32'h300);
    repeat (3) tick();

    // PC wrap at 2^32
    out_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    #1;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    tick();
    check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr2", imem_addr, 32'h0);
    check("wrap_req2", imem_req, 1);
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_pc == 32'hFFFF_FFFC) && n < 20) begin
      tick();
      n++;
    end
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc_next", out_pc_next, 32'h0);
    repeat (3) tick();

    // Fill FIFO, then reset asynchronously mid-cycle
    out_ready = 1'b0;
    repeat (8) tick();
    check("full_valid", out_valid, 1);
`ifdef IFETCH_PERF_EN
    check("perf_fetched", perf_fetched, tb_pops);
    check("perf_stall", perf_stall, tb_stalls);
`endif
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_req", imem_req, 0);
    check("arst_instr", out_instr, 0);
    check("arst_pc", out_pc, 0);
    check("arst_pc_next", out_pc_next, 0);
`ifdef IFETCH_PERF_EN
    check("arst_perf_fetched", perf_fetched, 0);
    check("arst_perf_stall", perf_stall, 0);
`endif
    repeat (2) tick();
    reset = 1'b1;
    sb_fill(32'h0);
    out_ready = 1'b1;
    #1;
    check("rst2_req", imem_req, 1);
    check("rst2_addr", imem_addr, 32'h0);
    tick();
    tick();
    check("rst2_valid", out_valid, 1);
    check("rst2_pc", out_pc, 32'h0);
    repeat (4) tick();
    out_ready = 1'b0;
    repeat (3) tick();
`ifdef IFETCH_PERF_EN
    check("perf_fetched_end", perf_fetched, tb_pops);
    check("perf_stall_end", perf_stall, tb_stalls);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
